reg_operand_fetch: RTL and testbench
====================================

// Module: reg_operand_fetch
// PURPOSE
//  Issue/operand-fetch stage directly upstream of the 32x16 register file. Decodes each
//  instruction into register-file read addresses, captures both source operands (with
//  writeback bypass), tracks in-flight destinations in a scoreboard and stalls on hazards.
//  Presents a registered operand bundle to the execute stage via valid/ready.
// PARAMETERS
//  DATA_W  16  register/operand width
//  ADDR_W  5   register address width; scoreboard has 2**ADDR_W entries
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  in_valid      in   1       instruction offered
//  in_ready      out  1       instruction accepted when in_valid&&in_ready at clk edge
//  in_instr      in   32      [31:26] opcode ([31]=writes rd), [25:21] rd, [20:16] rs1, [15:11] rs2, [10:0] imm
//  rf_src1_addr  out  ADDR_W  = in_instr[20:16], combinational
//  rf_src2_addr  out  ADDR_W  = in_instr[15:11], combinational
//  rf_src1_data  in   DATA_W  register-file read data for rf_src1_addr (combinational read)
//  rf_src2_data  in   DATA_W  register-file read data for rf_src2_addr
//  wb_valid      in   1       writeback this cycle (same cycle regfile is written)
//  wb_addr       in   ADDR_W  writeback destination
//  wb_data       in   DATA_W  writeback value
//  flush         in   1       discard bundle held in output register
//  out_valid     out  1       operand bundle valid
//  out_ready     in   1       execute stage accepts bundle
//  out_opcode    out  6       registered opcode
//  out_rd        out  ADDR_W  registered destination
//  out_op1       out  DATA_W  registered operand 1
//  out_op2       out  DATA_W  registered operand 2
//  out_imm       out  11      registered immediate
//  busy_vec      out  2**ADDR_W scoreboard, bit n = Rn has write in flight
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, all out_* data=0, busy_vec=0; in_ready=0 while in reset.
//  hazard = in_valid && ((busy[rs1] && !(wb_valid&&wb_addr==rs1)) || same for rs2
//           || (in_instr[31] && busy[rd] && !(wb_valid&&wb_addr==rd)))  -- RAW and WAW.
//  in_ready = (!out_valid || out_ready) && !hazard && !flush.
//  Accept: at edge with in_valid&&in_ready, output register loads bundle; out_valid=1; latency 1 cycle.
//  Bypass: op1 = (wb_valid&&wb_addr==rs1) ? wb_data : rf_src1_data; likewise op2.
//  Scoreboard per edge: clear busy[wb_addr] on wb_valid; set busy[rd] on accept with in_instr[31].
//   Same-address set and clear in one cycle -> set wins (bit ends 1).
//  Downstream: out_valid drops at edge where out_ready=1 and no new accept; else holds all out_* stable.
//  flush (sync): out_valid->0 at next edge; if out_valid && out_opcode[5], busy[out_rd] cleared
//   (unless a wb to a different in-flight copy is impossible: WAW stall guarantees single owner).
//   No accept in a flush cycle.
//  wb_valid to a non-busy register: legal, busy stays 0.
//  All 32 registers tracked including R0 (no hardwired zero).
//  rst_n deasserted mid-stream: bundle and scoreboard lost; upstream must re-issue.
// TESTING
//  T1 reset: rst_n=0 mid-cycle -> out_valid=0, busy_vec=0 immediately, no clk needed.
//  T2 issue: R1=47,R2=74; instr rd=3,rs1=1,rs2=2,[31]=1 -> next cycle out_op1=47,out_op2=74, busy_vec[3]=1.
//  T3 RAW: following instr rs1=3 -> in_ready=0 until wb_valid,wb_addr=3,wb_data=121;
//     that cycle accepted, out_op1=121 (bypass), busy_vec[3]=0 after edge.
//  T4 backpressure: out_ready=0 for 3 cycles -> out_* stable, in_ready=0; out_ready=1 -> next bundle loads.
//  T5 set/clear collision: wb to R5 and accept rd=5 same edge -> busy_vec[5]=1.
//  T6 flush: out_valid=1 with rd=7 writing -> flush=1 -> out_valid=0, busy_vec[7]=0, no accept that cycle.

Source files
------------

// File: rtl/reg_operand_fetch_if.sv
// Handshake bundle between the issue stage, its instruction source and the execute stage.
// The master modport is the environment side; the slave modport is the operand-fetch stage.
interface reg_operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_opcode;
  logic [ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [10:0]       out_imm;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm
  );
endinterface

// File: rtl/reg_operand_fetch.sv
// Issue/operand-fetch stage: decodes source addresses, bypasses writeback data into the
// operands, tracks in-flight destinations in a scoreboard and stalls on RAW/WAW hazards.
module reg_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_operand_fetch_if.slave     bus,
  output logic [ADDR_W-1:0]      rf_src1_addr,
  output logic [ADDR_W-1:0]      rf_src2_addr,
  input  logic [DATA_W-1:0]      rf_src1_data,
  input  logic [DATA_W-1:0]      rf_src2_data,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   busy_vec
);

  localparam int NREG = 2**ADDR_W;

  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              writes_rd;
  logic              wb_hit_rs1;
  logic              wb_hit_rs2;
  logic              wb_hit_rd;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  assign rd        = bus.in_instr[21 +: ADDR_W];
  assign rs1       = bus.in_instr[16 +: ADDR_W];
  assign rs2       = bus.in_instr[11 +: ADDR_W];
  assign writes_rd = bus.in_instr[31];

  assign rf_src1_addr = rs1;
  assign rf_src2_addr = rs2;

  assign wb_hit_rs1 = wb_valid && (wb_addr == rs1);
  assign wb_hit_rs2 = wb_valid && (wb_addr == rs2);
  assign wb_hit_rd  = wb_valid && (wb_addr == rd);

  // A writeback landing this cycle resolves the hazard on that register, since its value is bypassed.
  assign hazard = bus.in_valid &&
                  ((busy[rs1] && !wb_hit_rs1) ||
                   (busy[rs2] && !wb_hit_rs2) ||
                   (writes_rd && busy[rd] && !wb_hit_rd));

  assign bus.in_ready = rst_n && (!bus.out_valid || bus.out_ready) && !hazard && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  assign op1 = wb_hit_rs1 ? wb_data : rf_src1_data;
  assign op2 = wb_hit_rs2 ? wb_data : rf_src2_data;

  assign busy_vec = busy;

  // Clears are applied before the set so a same-register set/clear leaves the bit set.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (flush && bus.out_valid && bus.out_opcode[5]) begin
      busy_nxt[bus.out_rd] = 1'b0;
    end
    if (accept && writes_rd) begin
      busy_nxt[rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_opcode <= '0;
      bus.out_rd     <= '0;
      bus.out_op1    <= '0;
      bus.out_op2    <= '0;
      bus.out_imm    <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid  <= 1'b1;
      bus.out_opcode <= bus.in_instr[31:26];
      bus.out_rd     <= rd;
      bus.out_op1    <= op1;
      bus.out_op2    <= op2;
      bus.out_imm    <= bus.in_instr[10:0];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed and randomized bench for reg_operand_fetch with a behavioural register file
// and an in-flight register set model.
module tb_reg_operand_fetch;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rf_src1_addr;
  logic [ADDR_W-1:0] rf_src2_addr;
  logic [DATA_W-1:0] rf_src1_data;
  logic [DATA_W-1:0] rf_src2_data;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic [31:0]       busy_vec;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] rf [32];

  reg_operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .rf_src1_addr (rf_src1_addr),
    .rf_src2_addr (rf_src2_addr),
    .rf_src1_data (rf_src1_data),
    .rf_src2_data (rf_src2_data),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .busy_vec     (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file sitting downstream of the stage: combinational read, written by writeback.
  assign rf_src1_data = rf[rf_src1_addr];
  assign rf_src2_data = rf[rf_src2_addr];
  always @(posedge clk) begin
    if (wb_valid) rf[wb_addr] <= wb_data;
  end

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [10:0] imm);
    return {opc, rd, rs1, rs2, imm};
  endfunction

  task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic ordy,
                               input logic wv, input logic [4:0] wa, input logic [15:0] wd,
                               input logic fl);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    wb_valid      = wv;
    wb_addr       = wa;
    wb_data       = wd;
    flush         = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model state for the randomized phase
  logic        m_valid;
  logic [5:0]  m_opcode;
  logic [4:0]  m_rd;
  logic [15:0] m_op1;
  logic [15:0] m_op2;
  logic [10:0] m_imm;
  logic [31:0] m_busy;

  logic [31:0] r_instr;
  logic        r_iv, r_wv, r_ordy, r_fl, r_writes;
  logic [4:0]  r_rd, r_rs1, r_rs2, r_wa;
  logic [15:0] r_wd;
  logic        e_ready, e_hazard, e_acc;
  int          busy_q[$];

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk(6'h20, 5'd1, 5'd2, 5'd3, 11'h0);
    bus.out_ready = 1'b0;
    wb_valid      = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
    flush         = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy_vec", busy_vec, 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_op1", 32'(bus.out_op1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload every register through writeback; writes to idle registers leave busy clear
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'(i),
                    (i == 1) ? 16'd47 : (i == 2) ? 16'd74 : 16'(16'h100 + i), 1'b0);
      tick();
    end
    checkOutput("preload_busy", busy_vec, 32'd0);

    $display("[TB] issue");
    applyStimulus(1'b1, mk(6'h21, 5'd3, 5'd1, 5'd2, 11'h005), 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
    checkOutput("t2_src1_addr", 32'(rf_src1_addr), 32'd1);
    checkOutput("t2_src2_addr", 32'(rf_src2_addr), 32'd2);
    checkOutput("t2_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("t2_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t2_op1", 32'(bus.out_op1), 32'd47);
    checkOutput("t2_op2", 32'(bus.out_op2), 32'd74);
    checkOutput("t2_rd", 32'(bus.out_rd), 32'd3);
    checkOutput("t2_opcode", 32'(bus.out_opcode), 32'h21);
    checkOutput("t2_imm", 32'(bus.out_imm), 32'h5);
    checkOutput("t2_busy", busy_vec, 32'h8);

    $display("[TB] RAW stall and bypass");
    applyStimulus(1'b1, mk(6'h22, 5'd4, 5'd3, 5'd0, 11'h007), 1'b1, 1'b0, 5'd0, 16'd0, 1'b0);
    checkOutput("t3_stall0", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("t3_drain", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, mk(6'h22, 5'd4, 5'd3, 5'd0, 11'h007), 1'b1, 1'b0, 5'd0, 16'd0, 1'b0);
    checkOutput("t3_stall1", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("t3_busy_held", busy_vec, 32'h8);
    applyStimulus(1'b1, mk(6'h22, 5'd4, 5'd3, 5'd0, 11'h007), 1'b1, 1'b1, 5'd3, 16'd121, 1'b0);
    checkOutput("t3_ready_wb", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("t3_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t3_op1_bypass", 32'(bus.out_op1), 32'd121);
    checkOutput("t3_op2", 32'(bus.out_op2), 32'h100);
    checkOutput("t3_busy", busy_vec, 32'h10);

    $display("[TB] backpressure");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, mk(6'h05, 5'd9, 5'd1, 5'd2, 11'h3ff), 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
      checkOutput("t4_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("t4_valid_hold", 32'(bus.out_valid), 32'd1);
      checkOutput("t4_op1_hold", 32'(bus.out_op1), 32'd121);
      checkOutput("t4_rd_hold", 32'(bus.out_rd), 32'd4);
      checkOutput("t4_opc_hold", 32'(bus.out_opcode), 32'h22);
    end
    applyStimulus(1'b1, mk(6'h05, 5'd9, 5'd1, 5'd2, 11'h3ff), 1'b1, 1'b0, 5'd0, 16'd0, 1'b0);
    checkOutput("t4_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("t4_opcode", 32'(bus.out_opcode), 32'h05);
    checkOutput("t4_op1", 32'(bus.out_op1), 32'd47);
    checkOutput("t4_imm", 32'(bus.out_imm), 32'h3ff);
    checkOutput("t4_busy", busy_vec, 32'h10);

    $display("[TB] set/clear collision");
    applyStimulus(1'b1, mk(6'h23, 5'd5, 5'd6, 5'd7, 11'h0), 1'b1, 1'b0, 5'd0, 16'd0, 1'b0);
    tick();
    checkOutput("t5_busy_set", busy_vec, 32'h30);
    applyStimulus(1'b1, mk(6'h24, 5'd5, 5'd5, 5'd1, 11'h0), 1'b1, 1'b1, 5'd5, 16'h5555, 1'b0);
    checkOutput("t5_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("t5_busy_collide", busy_vec, 32'h30);
    checkOutput("t5_op1", 32'(bus.out_op1), 32'h5555);
    checkOutput("t5_op2", 32'(bus.out_op2), 32'd47);

    $display("[TB] flush");
    applyStimulus(1'b1, mk(6'h27, 5'd7, 5'd1, 5'd2, 11'h0), 1'b1, 1'b0, 5'd0, 16'd0, 1'b0);
    tick();
    checkOutput("t6_pre_busy", busy_vec, 32'hB0);
    checkOutput("t6_pre_rd", 32'(bus.out_rd), 32'd7);
    applyStimulus(1'b1, mk(6'h06, 5'd8, 5'd0, 5'd0, 11'h0), 1'b0, 1'b0, 5'd0, 16'd0, 1'b1);
    checkOutput("t6_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("t6_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_busy", busy_vec, 32'h30);
    applyStimulus(1'b1, mk(6'h06, 5'd8, 5'd0, 5'd0, 11'h0), 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b1);
    tick();
    checkOutput("t6_flush_nowrite", busy_vec, 32'h30);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, mk(6'h2A, 5'd9, 5'd1, 5'd2, 11'h0), 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
    tick();
    checkOutput("t1_pre_busy", busy_vec, 32'h230);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t1_busy", busy_vec, 32'd0);
    checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t1_op1", 32'(bus.out_op1), 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;

    m_valid  = 1'b0;
    m_opcode = '0;
    m_rd     = '0;
    m_op1    = '0;
    m_op2    = '0;
    m_imm    = '0;
    m_busy   = '0;

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      r_iv    = ($urandom_range(9) < 7);
      r_instr = $urandom;
      if ($urandom_range(1) == 1) begin
        r_instr[25:21] = 5'($urandom_range(7));
        r_instr[20:16] = 5'($urandom_range(7));
        r_instr[15:11] = 5'($urandom_range(7));
      end
      busy_q.delete();
      for (int b = 0; b < 32; b++) if (m_busy[b]) busy_q.push_back(b);
      r_wv = ($urandom_range(9) < 4);
      if (busy_q.size() > 0 && $urandom_range(3) != 0)
        r_wa = 5'(busy_q[$urandom_range(busy_q.size() - 1)]);
      else
        r_wa = 5'($urandom_range(31));
      r_wd   = 16'($urandom);
      r_ordy = ($urandom_range(9) < 7);
      r_fl   = ($urandom_range(15) == 0);

      applyStimulus(r_iv, r_instr, r_ordy, r_wv, r_wa, r_wd, r_fl);

      r_rd     = r_instr[25:21];
      r_rs1    = r_instr[20:16];
      r_rs2    = r_instr[15:11];
      r_writes = r_instr[31];
      e_hazard = r_iv && ((m_busy[r_rs1] && !(r_wv && r_wa == r_rs1)) ||
                          (m_busy[r_rs2] && !(r_wv && r_wa == r_rs2)) ||
                          (r_writes && m_busy[r_rd] && !(r_wv && r_wa == r_rd)));
      e_ready  = (!m_valid || r_ordy) && !e_hazard && !r_fl;
      e_acc    = r_iv && e_ready;
      checkOutput("rnd_in_ready", 32'(bus.in_ready), 32'(e_ready));

      if (r_wv) m_busy[r_wa] = 1'b0;
      if (r_fl && m_valid && m_opcode[5]) m_busy[m_rd] = 1'b0;
      if (e_acc && r_writes) m_busy[r_rd] = 1'b1;
      if (r_fl) begin
        m_valid = 1'b0;
      end else if (e_acc) begin
        m_valid  = 1'b1;
        m_opcode = r_instr[31:26];
        m_rd     = r_rd;
        m_op1    = (r_wv && r_wa == r_rs1) ? r_wd : rf[r_rs1];
        m_op2    = (r_wv && r_wa == r_rs2) ? r_wd : rf[r_rs2];
        m_imm    = r_instr[10:0];
      end else if (r_ordy) begin
        m_valid = 1'b0;
      end

      tick();
      checkOutput("rnd_out_valid", 32'(bus.out_valid), 32'(m_valid));
      checkOutput("rnd_busy_vec", busy_vec, m_busy);
      if (m_valid) begin
        checkOutput("rnd_opcode", 32'(bus.out_opcode), 32'(m_opcode));
        checkOutput("rnd_rd", 32'(bus.out_rd), 32'(m_rd));
        checkOutput("rnd_op1", 32'(bus.out_op1), 32'(m_op1));
        checkOutput("rnd_op2", 32'(bus.out_op2), 32'(m_op2));
        checkOutput("rnd_imm", 32'(bus.out_imm), 32'(m_imm));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
